// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline datapath and the central control unit.
// The datapath side is the master; the control unit is the slave.
interface pipe_ctrl_if;
    logic [31:0] id_inst;
    logic        id_stall;
    logic        ex_cmp;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;

    logic        ext_sz;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_regwrite;
    logic [1:0]  ex_regsrc;
    logic [1:0]  ex_regdst;
    logic        ex_aluasrc;
    logic        ex_alubsrc;
    logic [3:0]  ex_aluop;
    logic [2:0]  ex_cmpop;
    logic        ex_isjr;
    logic [1:0]  ex_memmode;
    logic [1:0]  ex_memext;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [1:0]  pc_br;
    logic        ifid_clear;
    logic        idex_clear;

    modport master (
        output id_inst, id_stall, ex_cmp, mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        input  ext_sz, ex_memread, ex_memwrite, ex_regwrite, ex_regsrc, ex_regdst,
               ex_aluasrc, ex_alubsrc, ex_aluop, ex_cmpop, ex_isjr, ex_memmode,
               ex_memext, ex_rs, ex_rt, fwd_a, fwd_b, pc_br, ifid_clear, idex_clear
    );

    modport slave (
        input  id_inst, id_stall, ex_cmp, mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        output ext_sz, ex_memread, ex_memwrite, ex_regwrite, ex_regsrc, ex_regdst,
               ex_aluasrc, ex_alubsrc, ex_aluop, ex_cmpop, ex_isjr, ex_memmode,
               ex_memext, ex_rs, ex_rt, fwd_a, fwd_b, pc_br, ifid_clear, idex_clear
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Central MIPS pipeline control: ID decode, ID/EX control register,
// branch/JR redirect and ALU operand forwarding selects.
module pipe_ctrl_unit (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_JAL = 6'h03,
                           OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07,
                           OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                           OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F,
                           OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24,
                           OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                           F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09,
                           F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
                           F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
                           F_SLT = 6'h2A, F_SLTU = 6'h2B;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7,
                           ALU_SRA = 4'd8, ALU_SLT = 4'd9, ALU_SLTU = 4'd10, ALU_LUI = 4'd11;

    localparam logic [2:0] CMP_EQ = 3'd1, CMP_NE = 3'd2, CMP_LEZ = 3'd3, CMP_GTZ = 3'd4,
                           CMP_LTZ = 3'd5, CMP_GEZ = 3'd6;

    localparam logic [1:0] SRC_MEM = 2'd1, SRC_PC4 = 2'd2;
    localparam logic [1:0] DST_RD = 2'd0, DST_RT = 2'd1, DST_R31 = 2'd2;
    localparam logic [1:0] MODE_WORD = 2'd0, MODE_HALF = 2'd1, MODE_BYTE = 2'd2;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic [1:0] regsrc;
        logic [1:0] regdst;
        logic       aluasrc;
        logic       alubsrc;
        logic [3:0] aluop;
        logic [2:0] cmpop;
        logic       isjr;
        logic [1:0] memmode;
        logic [1:0] memext;
    } ctrl_t;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] inst_rs;
    logic [4:0] inst_rt;
    ctrl_t      dec;
    logic       dec_ext;
    ctrl_t      ex_ctrl;
    logic [4:0] ex_rs_q;
    logic [4:0] ex_rt_q;
    logic [1:0] pc_br_c;
    logic       flush;
    logic       unused_inst_bits;

    assign op      = bus.id_inst[31:26];
    assign funct   = bus.id_inst[5:0];
    assign inst_rs = bus.id_inst[25:21];
    assign inst_rt = bus.id_inst[20:16];
    assign unused_inst_bits = &{1'b0, bus.id_inst[15:6]};

    always_comb begin
        dec     = '0;
        dec_ext = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec.regwrite = 1'b1;
                dec.regdst   = DST_RD;
                case (funct)
                    F_SLL:          begin dec.aluasrc = 1'b1; dec.aluop = ALU_SLL; end
                    F_SRL:          begin dec.aluasrc = 1'b1; dec.aluop = ALU_SRL; end
                    F_SRA:          begin dec.aluasrc = 1'b1; dec.aluop = ALU_SRA; end
                    F_SLLV:         dec.aluop = ALU_SLL;
                    F_SRLV:         dec.aluop = ALU_SRL;
                    F_SRAV:         dec.aluop = ALU_SRA;
                    F_JR:           begin dec.isjr = 1'b1; dec.regwrite = 1'b0; end
                    F_JALR:         begin dec.isjr = 1'b1; dec.regsrc = SRC_PC4; end
                    F_ADD, F_ADDU:  dec.aluop = ALU_ADD;
                    F_SUB, F_SUBU:  dec.aluop = ALU_SUB;
                    F_AND:          dec.aluop = ALU_AND;
                    F_OR:           dec.aluop = ALU_OR;
                    F_XOR:          dec.aluop = ALU_XOR;
                    F_NOR:          dec.aluop = ALU_NOR;
                    F_SLT:          dec.aluop = ALU_SLT;
                    F_SLTU:         dec.aluop = ALU_SLTU;
                    default:        dec = '0;
                endcase
            end
            OP_REGIMM: begin
                // Only BLTZ (rt=0) and BGEZ (rt=1) are implemented
                if (inst_rt == 5'd0) begin
                    dec.cmpop = CMP_LTZ;
                    dec_ext   = 1'b1;
                end else if (inst_rt == 5'd1) begin
                    dec.cmpop = CMP_GEZ;
                    dec_ext   = 1'b1;
                end
            end
            OP_JAL: begin
                dec.regwrite = 1'b1;
                dec.regsrc   = SRC_PC4;
                dec.regdst   = DST_R31;
            end
            OP_BEQ:  begin dec.cmpop = CMP_EQ;  dec_ext = 1'b1; end
            OP_BNE:  begin dec.cmpop = CMP_NE;  dec_ext = 1'b1; end
            OP_BLEZ: begin dec.cmpop = CMP_LEZ; dec_ext = 1'b1; end
            OP_BGTZ: begin dec.cmpop = CMP_GTZ; dec_ext = 1'b1; end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.regwrite = 1'b1;
                dec.regdst   = DST_RT;
                dec.alubsrc  = 1'b1;
                case (op)
                    OP_ADDI, OP_ADDIU: begin dec.aluop = ALU_ADD;  dec_ext = 1'b1; end
                    OP_SLTI:           begin dec.aluop = ALU_SLT;  dec_ext = 1'b1; end
                    OP_SLTIU:          begin dec.aluop = ALU_SLTU; dec_ext = 1'b1; end
                    OP_ANDI:           dec.aluop = ALU_AND;
                    OP_ORI:            dec.aluop = ALU_OR;
                    OP_XORI:           dec.aluop = ALU_XOR;
                    default:           dec.aluop = ALU_LUI;
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                dec.memread  = 1'b1;
                dec.regwrite = 1'b1;
                dec.regsrc   = SRC_MEM;
                dec.regdst   = DST_RT;
                dec.alubsrc  = 1'b1;
                dec.aluop    = ALU_ADD;
                dec_ext      = 1'b1;
                case (op)
                    OP_LB:   begin dec.memmode = MODE_BYTE; dec.memext = 2'd1; end
                    OP_LH:   begin dec.memmode = MODE_HALF; dec.memext = 2'd1; end
                    OP_LBU:  dec.memmode = MODE_BYTE;
                    OP_LHU:  dec.memmode = MODE_HALF;
                    default: dec.memmode = MODE_WORD;
                endcase
            end
            OP_SB, OP_SH, OP_SW: begin
                dec.memwrite = 1'b1;
                dec.alubsrc  = 1'b1;
                dec.aluop    = ALU_ADD;
                dec_ext      = 1'b1;
                case (op)
                    OP_SB:   dec.memmode = MODE_BYTE;
                    OP_SH:   dec.memmode = MODE_HALF;
                    default: dec.memmode = MODE_WORD;
                endcase
            end
            default: begin
                dec     = '0;
                dec_ext = 1'b0;
            end
        endcase
    end

    // A redirect out of EX and a load-use stall both turn ID/EX into a bubble;
    // source IDs are still captured so forwarding compares stay defined.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl <= '0;
            ex_rs_q <= '0;
            ex_rt_q <= '0;
        end else begin
            ex_rs_q <= inst_rs;
            ex_rt_q <= inst_rt;
            if (bus.id_stall || flush) ex_ctrl <= '0;
            else                       ex_ctrl <= dec;
        end
    end

    always_comb begin
        pc_br_c = 2'd0;
        if (ex_ctrl.isjr)    pc_br_c = 2'd1;
        else if (bus.ex_cmp) pc_br_c = 2'd2;
    end

    assign flush = (pc_br_c != 2'd0);

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] m_rd, input logic m_we,
                                           input logic [4:0] w_rd, input logic w_we);
        if (m_we && (m_rd != 5'd0) && (m_rd == src))      return 2'd2;
        else if (w_we && (w_rd != 5'd0) && (w_rd == src)) return 2'd1;
        else                                              return 2'd0;
    endfunction

    assign bus.fwd_a = fwd_sel(ex_rs_q, bus.mem_rd, bus.mem_regwrite, bus.wb_rd, bus.wb_regwrite);
    assign bus.fwd_b = fwd_sel(ex_rt_q, bus.mem_rd, bus.mem_regwrite, bus.wb_rd, bus.wb_regwrite);

    assign bus.ext_sz      = dec_ext;
    assign bus.ex_memread  = ex_ctrl.memread;
    assign bus.ex_memwrite = ex_ctrl.memwrite;
    assign bus.ex_regwrite = ex_ctrl.regwrite;
    assign bus.ex_regsrc   = ex_ctrl.regsrc;
    assign bus.ex_regdst   = ex_ctrl.regdst;
    assign bus.ex_aluasrc  = ex_ctrl.aluasrc;
    assign bus.ex_alubsrc  = ex_ctrl.alubsrc;
    assign bus.ex_aluop    = ex_ctrl.aluop;
    assign bus.ex_cmpop    = ex_ctrl.cmpop;
    assign bus.ex_isjr     = ex_ctrl.isjr;
    assign bus.ex_memmode  = ex_ctrl.memmode;
    assign bus.ex_memext   = ex_ctrl.memext;
    assign bus.ex_rs       = ex_rs_q;
    assign bus.ex_rt       = ex_rt_q;
    assign bus.pc_br       = pc_br_c;
    assign bus.ifid_clear  = flush;
    assign bus.idex_clear  = flush;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed plan items, then random
// instruction streams checked against a table-driven instruction model.
module tb_pipe_ctrl_unit;
    typedef struct packed {
        logic       mr;
        logic       mw;
        logic       rw;
        logic [1:0] rsrc;
        logic [1:0] rdst;
        logic       asrc;
        logic       bsrc;
        logic [3:0] aluop;
        logic [2:0] cmpop;
        logic       isjr;
        logic [1:0] mmode;
        logic [1:0] mext;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        int         sel;
        ctl_t       c;
        logic       ext;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    pipe_ctrl_if bus ();

    pipe_ctrl_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    ent_t table_q[$];
    logic [30:0] exp_q[$];
    logic [30:0] cur_ex;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ctl_t ctl(input int mr, mw, rw, rsrc, rdst, asrc, bsrc, aluop, cmpop, isjr, mmode, mext);
        ctl_t c;
        c = '{mr: 1'(mr), mw: 1'(mw), rw: 1'(rw), rsrc: 2'(rsrc), rdst: 2'(rdst), asrc: 1'(asrc),
              bsrc: 1'(bsrc), aluop: 4'(aluop), cmpop: 3'(cmpop), isjr: 1'(isjr),
              mmode: 2'(mmode), mext: 2'(mext)};
        return c;
    endfunction

    task automatic add_ent(input logic [5:0] op, input int sel, input ctl_t c, input logic ext);
        ent_t e;
        e.op = op; e.sel = sel; e.c = c; e.ext = ext;
        table_q.push_back(e);
    endtask

    // Instruction set as listed in the ISA description, one row per mnemonic
    task automatic build_table();
        add_ent(6'h00, 'h00, ctl(0,0,1,0,0,1,0, 6,0,0,0,0), 0); // sll
        add_ent(6'h00, 'h02, ctl(0,0,1,0,0,1,0, 7,0,0,0,0), 0); // srl
        add_ent(6'h00, 'h03, ctl(0,0,1,0,0,1,0, 8,0,0,0,0), 0); // sra
        add_ent(6'h00, 'h04, ctl(0,0,1,0,0,0,0, 6,0,0,0,0), 0); // sllv
        add_ent(6'h00, 'h06, ctl(0,0,1,0,0,0,0, 7,0,0,0,0), 0); // srlv
        add_ent(6'h00, 'h07, ctl(0,0,1,0,0,0,0, 8,0,0,0,0), 0); // srav
        add_ent(6'h00, 'h08, ctl(0,0,0,0,0,0,0, 0,0,1,0,0), 0); // jr
        add_ent(6'h00, 'h09, ctl(0,0,1,2,0,0,0, 0,0,1,0,0), 0); // jalr
        add_ent(6'h00, 'h20, ctl(0,0,1,0,0,0,0, 0,0,0,0,0), 0); // add
        add_ent(6'h00, 'h21, ctl(0,0,1,0,0,0,0, 0,0,0,0,0), 0); // addu
        add_ent(6'h00, 'h22, ctl(0,0,1,0,0,0,0, 1,0,0,0,0), 0); // sub
        add_ent(6'h00, 'h23, ctl(0,0,1,0,0,0,0, 1,0,0,0,0), 0); // subu
        add_ent(6'h00, 'h24, ctl(0,0,1,0,0,0,0, 2,0,0,0,0), 0); // and
        add_ent(6'h00, 'h25, ctl(0,0,1,0,0,0,0, 3,0,0,0,0), 0); // or
        add_ent(6'h00, 'h26, ctl(0,0,1,0,0,0,0, 4,0,0,0,0), 0); // xor
        add_ent(6'h00, 'h27, ctl(0,0,1,0,0,0,0, 5,0,0,0,0), 0); // nor
        add_ent(6'h00, 'h2A, ctl(0,0,1,0,0,0,0, 9,0,0,0,0), 0); // slt
        add_ent(6'h00, 'h2B, ctl(0,0,1,0,0,0,0,10,0,0,0,0), 0); // sltu
        add_ent(6'h01, 0,    ctl(0,0,0,0,0,0,0, 0,5,0,0,0), 1); // bltz
        add_ent(6'h01, 1,    ctl(0,0,0,0,0,0,0, 0,6,0,0,0), 1); // bgez
        add_ent(6'h02, -1,   ctl(0,0,0,0,0,0,0, 0,0,0,0,0), 0); // j
        add_ent(6'h03, -1,   ctl(0,0,1,2,2,0,0, 0,0,0,0,0), 0); // jal
        add_ent(6'h04, -1,   ctl(0,0,0,0,0,0,0, 0,1,0,0,0), 1); // beq
        add_ent(6'h05, -1,   ctl(0,0,0,0,0,0,0, 0,2,0,0,0), 1); // bne
        add_ent(6'h06, -1,   ctl(0,0,0,0,0,0,0, 0,3,0,0,0), 1); // blez
        add_ent(6'h07, -1,   ctl(0,0,0,0,0,0,0, 0,4,0,0,0), 1); // bgtz
        add_ent(6'h08, -1,   ctl(0,0,1,0,1,0,1, 0,0,0,0,0), 1); // addi
        add_ent(6'h09, -1,   ctl(0,0,1,0,1,0,1, 0,0,0,0,0), 1); // addiu
        add_ent(6'h0A, -1,   ctl(0,0,1,0,1,0,1, 9,0,0,0,0), 1); // slti
        add_ent(6'h0B, -1,   ctl(0,0,1,0,1,0,1,10,0,0,0,0), 1); // sltiu
        add_ent(6'h0C, -1,   ctl(0,0,1,0,1,0,1, 2,0,0,0,0), 0); // andi
        add_ent(6'h0D, -1,   ctl(0,0,1,0,1,0,1, 3,0,0,0,0), 0); // ori
        add_ent(6'h0E, -1,   ctl(0,0,1,0,1,0,1, 4,0,0,0,0), 0); // xori
        add_ent(6'h0F, -1,   ctl(0,0,1,0,1,0,1,11,0,0,0,0), 0); // lui
        add_ent(6'h20, -1,   ctl(1,0,1,1,1,0,1, 0,0,0,2,1), 1); // lb
        add_ent(6'h21, -1,   ctl(1,0,1,1,1,0,1, 0,0,0,1,1), 1); // lh
        add_ent(6'h23, -1,   ctl(1,0,1,1,1,0,1, 0,0,0,0,0), 1); // lw
        add_ent(6'h24, -1,   ctl(1,0,1,1,1,0,1, 0,0,0,2,0), 1); // lbu
        add_ent(6'h25, -1,   ctl(1,0,1,1,1,0,1, 0,0,0,1,0), 1); // lhu
        add_ent(6'h28, -1,   ctl(0,1,0,0,0,0,1, 0,0,0,2,0), 1); // sb
        add_ent(6'h29, -1,   ctl(0,1,0,0,0,0,1, 0,0,0,1,0), 1); // sh
        add_ent(6'h2B, -1,   ctl(0,1,0,0,0,0,1, 0,0,0,0,0), 1); // sw
    endtask

    function automatic ent_t ref_lookup(input logic [31:0] inst);
        ent_t r;
        int   sub;
        r.op = inst[31:26]; r.sel = -1; r.c = '0; r.ext = 1'b0;
        sub = (inst[31:26] == 6'h00) ? int'(inst[5:0]) : int'(inst[20:16]);
        foreach (table_q[i])
            if (table_q[i].op == inst[31:26] && (table_q[i].sel < 0 || table_q[i].sel == sub))
                r = table_q[i];
        return r;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (bus.mem_regwrite && bus.mem_rd != 0 && bus.mem_rd == src) return 2'd2;
        if (bus.wb_regwrite && bus.wb_rd != 0 && bus.wb_rd == src)    return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [30:0] dut_ex();
        return {bus.ex_memread, bus.ex_memwrite, bus.ex_regwrite, bus.ex_regsrc, bus.ex_regdst,
                bus.ex_aluasrc, bus.ex_alubsrc, bus.ex_aluop, bus.ex_cmpop, bus.ex_isjr,
                bus.ex_memmode, bus.ex_memext, bus.ex_rs, bus.ex_rt};
    endfunction

    task automatic drive(input logic [31:0] inst, input logic stall, input logic cmp,
                         input logic [4:0] mrd, input logic mrw,
                         input logic [4:0] wrd, input logic wrw, input logic r);
        @(negedge clk);
        bus.id_inst = inst; bus.id_stall = stall; bus.ex_cmp = cmp;
        bus.mem_rd = mrd; bus.mem_regwrite = mrw; bus.wb_rd = wrd; bus.wb_regwrite = wrw;
        rst = r;
        #1;
    endtask

    // Check the combinational outputs, predict the next ID/EX content, clock, compare.
    task automatic check_and_clock();
        ctl_t        c;
        ent_t        e;
        logic [1:0]  exp_pc;
        logic [30:0] nxt;
        c      = ctl_t'(cur_ex[30:10]);
        e      = ref_lookup(bus.id_inst);
        exp_pc = c.isjr ? 2'd1 : (bus.ex_cmp ? 2'd2 : 2'd0);
        check_val("ext_sz", 32'(bus.ext_sz), 32'(e.ext));
        check_val("pc_br", 32'(bus.pc_br), 32'(exp_pc));
        check_val("ifid_clear", 32'(bus.ifid_clear), 32'(exp_pc != 0));
        check_val("idex_clear", 32'(bus.idex_clear), 32'(exp_pc != 0));
        check_val("fwd_a", 32'(bus.fwd_a), 32'(ref_fwd(cur_ex[9:5])));
        check_val("fwd_b", 32'(bus.fwd_b), 32'(ref_fwd(cur_ex[4:0])));
        if (rst)                            nxt = '0;
        else if (bus.id_stall || exp_pc != 0) nxt = {21'b0, bus.id_inst[25:21], bus.id_inst[20:16]};
        else                                nxt = {e.c, bus.id_inst[25:21], bus.id_inst[20:16]};
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        nxt = exp_q.pop_front();
        check_val("idex_reg", 32'(dut_ex()), 32'(nxt));
        cur_ex = nxt;
    endtask

    function automatic logic [31:0] rand_inst();
        ent_t        e;
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 5) == 0) return w;
        e = table_q[$urandom_range(0, table_q.size() - 1)];
        w[31:26] = e.op;
        if (e.op == 6'h00) w[5:0] = 6'(e.sel);
        if (e.op == 6'h01) w[20:16] = 5'(e.sel);
        return w;
    endfunction

    localparam logic [31:0] I_ADD = 32'h0022_1820; // add $3,$1,$2
    localparam logic [31:0] I_LW  = 32'h8C85_0008; // lw $5,8($4)
    localparam logic [31:0] I_BEQ = 32'h1022_0003; // beq $1,$2,+3
    localparam logic [31:0] I_JR  = 32'h03E0_0008; // jr $31
    localparam logic [31:0] I_RS3 = 32'h0060_1020; // add $2,$3,$0

    initial begin
        ctl_t c;
        build_table();
        bus.id_inst = '0; bus.id_stall = 0; bus.ex_cmp = 0;
        bus.mem_rd = '0; bus.mem_regwrite = 0; bus.wb_rd = '0; bus.wb_regwrite = 0;
        repeat (2) @(posedge clk);
        #1;
        cur_ex = '0;
        check_val("reset_ex", 32'(dut_ex()), 32'h0);
        check_val("reset_pc_br", 32'(bus.pc_br), 32'h0);
        check_val("reset_clears", 32'({bus.ifid_clear, bus.idex_clear}), 32'h0);

        drive(I_ADD, 0, 0, 0, 0, 0, 0, 0); check_and_clock();
        check_val("add_regwrite", 32'(bus.ex_regwrite), 32'd1);
        check_val("add_regdst", 32'(bus.ex_regdst), 32'd0);
        check_val("add_aluop", 32'(bus.ex_aluop), 32'd0);
        check_val("add_rs", 32'(bus.ex_rs), 32'd1);
        check_val("add_rt", 32'(bus.ex_rt), 32'd2);
        check_val("add_pc_br", 32'(bus.pc_br), 32'd0);

        drive(I_LW, 0, 0, 0, 0, 0, 0, 0); check_and_clock();
        check_val("lw_ctl", 32'({bus.ex_memread, bus.ex_regsrc, bus.ex_regdst, bus.ex_alubsrc, bus.ex_memmode}),
                  32'({1'b1, 2'd1, 2'd1, 1'b1, 2'd0}));
        drive(I_LW, 1, 0, 0, 0, 0, 0, 0); check_and_clock();
        check_val("stall_bubble", 32'(dut_ex() >> 10), 32'h0);
        check_val("stall_rs", 32'(bus.ex_rs), 32'd4);

        drive(I_BEQ, 0, 0, 0, 0, 0, 0, 0); check_and_clock();
        drive(I_ADD, 0, 1, 0, 0, 0, 0, 0);
        check_val("beq_taken_pc_br", 32'(bus.pc_br), 32'd2);
        check_val("beq_taken_clr", 32'({bus.ifid_clear, bus.idex_clear}), 32'h3);
        check_and_clock();
        check_val("beq_flush_bubble", 32'(dut_ex() >> 10), 32'h0);
        drive(I_BEQ, 0, 0, 0, 0, 0, 0, 0); check_and_clock();
        drive(I_ADD, 0, 0, 0, 0, 0, 0, 0);
        check_val("beq_not_taken", 32'(bus.pc_br), 32'd0);
        check_and_clock();

        drive(I_JR, 0, 0, 0, 0, 0, 0, 0); check_and_clock();
        drive(I_ADD, 0, 0, 0, 0, 0, 0, 0);
        check_val("jr_pc_br", 32'(bus.pc_br), 32'd1);
        check_val("jr_clr", 32'({bus.ifid_clear, bus.idex_clear}), 32'h3);
        check_and_clock();
        check_val("jr_flush_bubble", 32'(dut_ex() >> 10), 32'h0);

        drive(I_RS3, 0, 0, 0, 0, 0, 0, 0); check_and_clock();
        drive(I_ADD, 0, 0, 5'd3, 1, 5'd3, 1, 0);
        check_val("fwd_a_mem", 32'(bus.fwd_a), 32'd2);
        bus.mem_regwrite = 0; #1;
        check_val("fwd_a_wb", 32'(bus.fwd_a), 32'd1);
        bus.mem_regwrite = 1; bus.mem_rd = 0; bus.wb_rd = 0; #1;
        check_val("fwd_a_r0", 32'(bus.fwd_a), 32'd0);
        check_and_clock();

        drive(32'h3402_FFFF, 0, 0, 0, 0, 0, 0, 0);
        check_val("ori_ext", 32'(bus.ext_sz), 32'd0);
        check_and_clock();
        check_val("ori_aluop", 32'(bus.ex_aluop), 32'd3);
        drive(32'h2002_FFFF, 0, 0, 0, 0, 0, 0, 0);
        check_val("addi_ext", 32'(bus.ext_sz), 32'd1);
        check_and_clock();
        drive(32'hFC00_0000, 0, 0, 0, 0, 0, 0, 0); check_and_clock();
        check_val("unknown_nop", 32'(dut_ex() >> 10), 32'h0);

        drive(I_ADD, 0, 0, 0, 0, 0, 0, 1); check_and_clock();
        check_val("midop_reset", 32'(dut_ex()), 32'h0);

        for (int i = 0; i < 600; i++) begin
            logic cmp;
            c   = ctl_t'(cur_ex[30:10]);
            cmp = (c.cmpop != 0 || c.isjr) ? 1'($urandom_range(0, 1)) : 1'b0;
            drive(rand_inst(), ($urandom_range(0, 5) == 0), cmp,
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 40) == 0));
            check_and_clock();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
